// File: rtl/bconv_pkg.sv
// bconv_pkg: shared types and constants for the binary-convolution engine.
//   - state_t : controller states
//   - T / M_MAX : threshold and maximum output width for the default geometry
//   - header field positions for the N (image size) and K (kernel count) words
//   - thresh() : majority threshold for an arbitrary kernel edge
package bconv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_HDR,
        LD_KERN,
        FILL,
        COMPUTE,
        DONE
    } state_t;

    localparam int DATA_W_DEF = 16;
    localparam int KS_DEF     = 3;

    // Majority threshold: a pixel fires when at least half (rounded up)
    // of the window positions agree with the kernel.
    localparam int T     = (KS_DEF * KS_DEF + 1) / 2;
    localparam int M_MAX = DATA_W_DEF - KS_DEF + 1;

    // Header words: N lives in SRAM[IN_BASE][4:0], K in WMEM[W_BASE][3:0].
    localparam int HDR_N_LSB = 0;
    localparam int HDR_N_W   = 5;
    localparam int HDR_K_LSB = 0;
    localparam int HDR_K_W   = 4;

    function automatic int thresh(input int ks);
        return (ks * ks + 1) / 2;
    endfunction

endpackage

// File: rtl/bconv_row_pop.sv
// bconv_row_pop: combinational XNOR-popcount-threshold for one output row.
//   i_rows : KS buffered image rows, i_rows[i] is window row i
//   i_kern : kernel, bit KS*i+j = weight (i,j)
//   o_bits : bit c = 1 iff matches of window at column c >= threshold
// Columns beyond the valid output width are not masked here; the caller
// masks them with the current output width.
module bconv_row_pop
    import bconv_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int KS     = 3
) (
    input  logic [KS-1:0][DATA_W-1:0] i_rows,
    input  logic [KS*KS-1:0]          i_kern,
    output logic [DATA_W-1:0]         o_bits
);

    localparam int T_L = thresh(KS);

    // Zero-pad each row so window columns past the word edge stay in range.
    logic [KS-1:0][DATA_W+KS-1:0] w_pad;
    int                           v_cnt;

    always_comb begin
        for (int i = 0; i < KS; i++) begin
            w_pad[i] = {{KS{1'b0}}, i_rows[i]};
        end
    end

    always_comb begin
        o_bits = '0;
        v_cnt  = 0;
        for (int c = 0; c < DATA_W; c++) begin
            v_cnt = 0;
            for (int i = 0; i < KS; i++) begin
                for (int j = 0; j < KS; j++) begin
                    v_cnt = v_cnt + ((w_pad[i][c+j] ~^ i_kern[KS*i+j]) ? 1 : 0);
                end
            end
            o_bits[c] = (v_cnt >= T_L);
        end
    end

endmodule

// File: rtl/bconv_engine.sv
// bconv_engine: binary-convolution controller and datapath.
// Reads an N x N binary image from SRAM and K kernels from WMEM, and for each
// kernel writes M = N-KS+1 packed output rows to SRAM at OUT_BASE+k*M+r.
// The image is re-streamed per kernel through a KS-deep row shift buffer.
//   clk, reset_b                 : clock, async active-low reset
//   dut_run                      : start request (sampled in IDLE)
//   dut_busy                     : job in progress
//   dut_error                    : sticky bad-header flag
//   dut_sram_read_address / sram_dut_read_data : image reads (1-cycle latency)
//   dut_wmem_read_address / wmem_dut_read_data : weight reads (1-cycle latency)
//   dut_sram_write_enable/_address/_data       : output row writes
// Memory handshake: an address presented in cycle t returns data that is
// captured at the end of t+1; writes are single-cycle strobes with address
// and data valid in the same cycle, no back-pressure.
module bconv_engine
    import bconv_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 12,
    parameter int KS       = 3,
    parameter int MAX_K    = 8,
    parameter int IN_BASE  = 0,
    parameter int W_BASE   = 0,
    parameter int OUT_BASE = 128
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic              dut_error,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_wmem_read_address,
    input  logic [DATA_W-1:0] wmem_dut_read_data,
    output logic              dut_sram_write_enable,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data
);

    localparam logic [5:0]        KS_C     = 6'(KS);
    localparam logic [5:0]        DW_C     = 6'(DATA_W);
    localparam logic [3:0]        MAXK_C   = 4'(MAX_K);
    localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_IN_HDR = ADDR_W'(IN_BASE);
    localparam logic [ADDR_W-1:0] A_IN_R0  = ADDR_W'(IN_BASE + 1);
    localparam logic [ADDR_W-1:0] A_W_HDR  = ADDR_W'(W_BASE);
    localparam logic [ADDR_W-1:0] A_W_K0   = ADDR_W'(W_BASE + 1);
    localparam logic [ADDR_W-1:0] A_OUT    = ADDR_W'(OUT_BASE);

    state_t                   r_state;
    state_t                   w_next;
    logic [5:0]               r_cnt;       // phase / fill / output-row counter
    logic [5:0]               r_m;         // output rows per kernel
    logic [3:0]               r_k;         // current kernel
    logic [3:0]               r_klast;     // K-1
    logic [KS*KS-1:0]         r_kern;
    logic [KS-1:0][DATA_W-1:0] r_rows;
    logic [ADDR_W-1:0]        r_sram_addr;
    logic [ADDR_W-1:0]        r_wmem_addr;
    logic [ADDR_W-1:0]        r_wr_addr;
    logic                     r_error;

    logic [5:0]               w_hdr_n;
    logic [3:0]               w_hdr_k;
    logic                     w_hdr_legal;
    logic                     w_last_row;
    logic [DATA_W-1:0]        w_pop;
    logic [DATA_W-1:0]        w_mask;
    logic                     w_unused;

    assign w_hdr_n     = {1'b0, sram_dut_read_data[HDR_N_LSB +: HDR_N_W]};
    assign w_hdr_k     = wmem_dut_read_data[HDR_K_LSB +: HDR_K_W];
    assign w_hdr_legal = (w_hdr_n >= KS_C) && (w_hdr_n <= DW_C) &&
                         (w_hdr_k != 4'd0) && (w_hdr_k <= MAXK_C);
    assign w_last_row  = (r_cnt == r_m - 6'd1);
    // Upper weight bits are don't-care; keep them referenced.
    assign w_unused    = ^wmem_dut_read_data;

    bconv_row_pop #(
        .DATA_W (DATA_W),
        .KS     (KS)
    ) u_row_pop (
        .i_rows (r_rows),
        .i_kern (r_kern),
        .o_bits (w_pop)
    );

    always_comb begin
        w_mask = '0;
        for (int c = 0; c < DATA_W; c++) begin
            w_mask[c] = (c < int'(r_m));
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. RD_HDR and LD_KERN take two cycles: issue, then capture.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (dut_run) w_next = RD_HDR;
            RD_HDR:  if (r_cnt == 6'd1) w_next = w_hdr_legal ? LD_KERN : DONE;
            LD_KERN: if (r_cnt == 6'd1) w_next = FILL;
            FILL:    if (r_cnt == KS_C) w_next = COMPUTE;
            COMPUTE: if (w_last_row) w_next = (r_k == r_klast) ? DONE : LD_KERN;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: counters, header latch, kernel latch, row buffer, addresses.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_cnt       <= '0;
            r_m         <= '0;
            r_k         <= '0;
            r_klast     <= '0;
            r_kern      <= '0;
            r_rows      <= '0;
            r_sram_addr <= '0;
            r_wmem_addr <= '0;
            r_wr_addr   <= '0;
            r_error     <= 1'b0;
        end else begin
            r_cnt <= (w_next != r_state) ? 6'd0 : r_cnt + 6'd1;
            case (r_state)
                IDLE: begin
                    if (dut_run) begin
                        r_error     <= 1'b0;
                        r_k         <= '0;
                        r_sram_addr <= A_IN_HDR;
                        r_wmem_addr <= A_W_HDR;
                        r_wr_addr   <= A_OUT;
                    end
                end
                RD_HDR: begin
                    if (r_cnt == 6'd1) begin
                        r_m         <= w_hdr_n - KS_C + 6'd1;
                        r_klast     <= w_hdr_k - 4'd1;
                        r_wmem_addr <= A_W_K0;
                        if (!w_hdr_legal) r_error <= 1'b1;
                    end
                end
                LD_KERN: begin
                    if (r_cnt == 6'd1) begin
                        r_kern      <= wmem_dut_read_data[KS*KS-1:0];
                        r_sram_addr <= A_IN_R0;
                    end
                end
                FILL: begin
                    // Reads run back-to-back; data lags the address by one cycle.
                    r_sram_addr <= r_sram_addr + A_ONE;
                    if (r_cnt != 6'd0) begin
                        r_rows <= {sram_dut_read_data, r_rows[KS-1:1]};
                    end
                end
                COMPUTE: begin
                    r_wr_addr   <= r_wr_addr + A_ONE;
                    r_sram_addr <= r_sram_addr + A_ONE;
                    if (!w_last_row) begin
                        r_rows <= {sram_dut_read_data, r_rows[KS-1:1]};
                    end else begin
                        r_k         <= r_k + 4'd1;
                        r_wmem_addr <= r_wmem_addr + A_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dut_busy               = (r_state != IDLE) && (r_state != DONE);
    assign dut_error              = r_error;
    assign dut_sram_read_address  = r_sram_addr;
    assign dut_wmem_read_address  = r_wmem_addr;
    // Strobe is decoded from the async-reset state so it drops with reset_b.
    assign dut_sram_write_enable  = (r_state == COMPUTE);
    assign dut_sram_write_address = r_wr_addr;
    assign dut_sram_write_data    = dut_sram_write_enable ? (w_pop & w_mask) : '0;

endmodule

// File: tb/tb_bconv_engine.sv
module tb_bconv_engine;

  logic        clk;
  logic        reset_b;
  logic        dut_run;
  logic        dut_busy;
  logic        dut_error;
  logic [11:0] dut_sram_read_address;
  logic [15:0] sram_dut_read_data;
  logic [11:0] dut_wmem_read_address;
  logic [15:0] wmem_dut_read_data;
  logic        dut_sram_write_enable;
  logic [11:0] dut_sram_write_address;
  logic [15:0] dut_sram_write_data;

  logic [15:0] sram [0:4095];
  logic [15:0] wmem [0:4095];

  logic [27:0] exp_q[$];
  int          n_checks;
  int          n_fail;
  int          n_writes;

  bconv_engine dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .dut_run                (dut_run),
    .dut_busy               (dut_busy),
    .dut_error              (dut_error),
    .dut_sram_read_address  (dut_sram_read_address),
    .sram_dut_read_data     (sram_dut_read_data),
    .dut_wmem_read_address  (dut_wmem_read_address),
    .wmem_dut_read_data     (wmem_dut_read_data),
    .dut_sram_write_enable  (dut_sram_write_enable),
    .dut_sram_write_address (dut_sram_write_address),
    .dut_sram_write_data    (dut_sram_write_data)
  );

  // clock / memories
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    sram_dut_read_data <= sram[dut_sram_read_address];
    wmem_dut_read_data <= wmem[dut_wmem_read_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write is popped against the expected queue
  always @(negedge clk) begin
    if (reset_b && dut_sram_write_enable) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {4'h0, dut_sram_write_address, dut_sram_write_data}, 32'hFFFF_FFFF);
      end else begin
        check("write", {4'h0, dut_sram_write_address, dut_sram_write_data}, {4'h0, exp_q.pop_front()});
      end
    end
  end

  // reference model: one output row of a 3x3 kernel over the SRAM image
  function automatic logic [15:0] ref_row(input int n, input int r, input logic [8:0] w);
    logic [15:0] res;
    logic [15:0] row;
    int cnt;
    res = '0;
    for (int c = 0; c < n - 2; c++) begin
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
        row = sram[1 + r + i];
        for (int j = 0; j < 3; j++) begin
          if (row[c + j] == w[3 * i + j]) cnt++;
        end
      end
      res[c] = (cnt >= 5);
    end
    return res;
  endfunction

  task automatic push_model(input int n, input int k);
    logic [15:0] w;
    for (int kk = 0; kk < k; kk++) begin
      w = wmem[1 + kk];
      for (int r = 0; r < n - 2; r++) begin
        exp_q.push_back({12'(128 + kk * (n - 2) + r), ref_row(n, r, w[8:0])});
      end
    end
  endtask

  task automatic push_exp(input int addr, input logic [15:0] data);
    exp_q.push_back({12'(addr), data});
  endtask

  task automatic load_random(input int n, input int k);
    sram[0] = 16'(n);
    wmem[0] = 16'(k);
    for (int r = 0; r < n; r++) sram[1 + r] = 16'($urandom_range(0, 65535));
    for (int kk = 0; kk < k; kk++) wmem[1 + kk] = 16'($urandom_range(0, 511));
  endtask

  task automatic run_job(input string tag, input int n, input int k, input bit exp_err, input int exp_w);
    int cyc;
    int bound;
    int w0;
    bound = exp_err ? 4 : 3 + k * (3 + (n - 2) + 3);
    w0 = n_writes;
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    check({tag, "_busy_rise"}, 32'(dut_busy), 32'd1);
    cyc = 1;
    while (dut_busy && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_job_len_within_bound"}, 32'(cyc <= bound), 32'd1);
    check({tag, "_error"}, 32'(dut_error), 32'(exp_err));
    check({tag, "_write_count"}, 32'(n_writes - w0), 32'(exp_w));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    int w0;
    n_checks = 0;
    n_fail   = 0;
    n_writes = 0;
    for (int a = 0; a < 4096; a++) begin
      sram[a] = '0;
      wmem[a] = '0;
    end
    reset_b = 1'b0;
    dut_run = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_busy",  32'(dut_busy), 32'd0);
    check("rst_error", 32'(dut_error), 32'd0);
    check("rst_we",    32'(dut_sram_write_enable), 32'd0);
    check("rst_raddr", 32'(dut_sram_read_address), 32'd0);
    check("rst_waddr", 32'(dut_wmem_read_address), 32'd0);
    check("rst_oaddr", 32'(dut_sram_write_address), 32'd0);
    check("rst_odata", 32'(dut_sram_write_data), 32'd0);
    reset_b = 1'b1;
    repeat (2) @(negedge clk);

    // all-ones image, all-ones kernel
    sram[0] = 16'd4;
    for (int r = 0; r < 4; r++) sram[1 + r] = 16'h000F;
    wmem[0] = 16'd1;
    wmem[1] = 16'h01FF;
    push_exp(128, 16'h0003);
    push_exp(129, 16'h0003);
    run_job("ones", 4, 1, 1'b0, 2);

    // all-ones image, all-zero kernel
    wmem[1] = 16'h0000;
    push_exp(128, 16'h0000);
    push_exp(129, 16'h0000);
    run_job("zeros", 4, 1, 1'b0, 2);

    // random N=5, K=3 against the model
    load_random(5, 3);
    push_model(5, 3);
    run_job("rand5", 5, 3, 1'b0, 9);

    // threshold boundary: 5 matches -> 1, 4 matches -> 0 (N=3, one write per kernel)
    sram[0] = 16'd3;
    sram[1] = 16'h0007;
    sram[2] = 16'h0003;
    sram[3] = 16'h0000;
    wmem[0] = 16'd2;
    wmem[1] = 16'h01FF;
    wmem[2] = 16'h01FE;
    push_exp(128, 16'h0001);
    push_exp(129, 16'h0000);
    run_job("thresh", 3, 2, 1'b0, 2);

    // illegal headers
    sram[0] = 16'd2;  wmem[0] = 16'd1;
    run_job("bad_n2", 2, 1, 1'b1, 0);
    sram[0] = 16'd4;  wmem[0] = 16'd0;
    run_job("bad_k0", 4, 0, 1'b1, 0);
    sram[0] = 16'd17; wmem[0] = 16'd1;
    run_job("bad_n17", 17, 1, 1'b1, 0);

    // next legal run clears the error
    sram[0] = 16'd4;
    for (int r = 0; r < 4; r++) sram[1 + r] = 16'h000F;
    wmem[0] = 16'd1;
    wmem[1] = 16'h01FF;
    push_exp(128, 16'h0003);
    push_exp(129, 16'h0003);
    run_job("recover", 4, 1, 1'b0, 2);

    // reset mid-COMPUTE, then a full rerun
    load_random(6, 3);
    push_model(6, 3);
    w0 = n_writes;
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    cyc = 0;
    while (!(dut_sram_write_enable && (n_writes - w0) >= 2) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_reached_compute", 32'(dut_sram_write_enable), 32'd1);
    #2;
    reset_b = 1'b0;
    #1;
    check("midrst_we",    32'(dut_sram_write_enable), 32'd0);
    check("midrst_busy",  32'(dut_busy), 32'd0);
    check("midrst_error", 32'(dut_error), 32'd0);
    check("midrst_raddr", 32'(dut_sram_read_address), 32'd0);
    check("midrst_waddr", 32'(dut_wmem_read_address), 32'd0);
    check("midrst_oaddr", 32'(dut_sram_write_address), 32'd0);
    check("midrst_odata", 32'(dut_sram_write_data), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    repeat (2) @(negedge clk);
    push_model(6, 3);
    run_job("rerun6", 6, 3, 1'b0, 12);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
